// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: default widths, the $zero register index,
// the MEM->WB beat layout and the skid-buffer occupancy states.
package mips_pkg;

    localparam int unsigned MIPS_DATA_W     = 32;
    localparam int unsigned MIPS_REG_ADDR_W = 5;
    localparam int unsigned REG_ZERO        = 0;

    // Field order here is also the packing order used on the skid payload bus.
    typedef struct packed {
        logic [MIPS_DATA_W-1:0]     mem_data;
        logic [MIPS_DATA_W-1:0]     alu_data;
        logic [MIPS_REG_ADDR_W-1:0] wb_reg;
        logic                       reg_write;
        logic                       mem_to_reg;
    } wb_beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB handshake bundle: upstream beat offer, downstream held beat and
// the qualified write-back outputs. The pipeline register takes the slave side.
interface mem_wb_pipe_reg_if import mips_pkg::*; #(
    parameter int unsigned DATA_W     = MIPS_DATA_W,
    parameter int unsigned REG_ADDR_W = MIPS_REG_ADDR_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     alu_data_in;
    logic [REG_ADDR_W-1:0] wb_reg_in;
    logic                  reg_write_in;
    logic                  mem_to_reg_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     mem_data_out;
    logic [DATA_W-1:0]     alu_data_out;
    logic [REG_ADDR_W-1:0] wb_reg_out;
    logic                  reg_write_out;
    logic [DATA_W-1:0]     wb_data_out;

    modport master (
        output in_valid, mem_data_in, alu_data_in, wb_reg_in, reg_write_in, mem_to_reg_in,
        output out_ready,
        input  in_ready,
        input  out_valid, mem_data_out, alu_data_out, wb_reg_out, reg_write_out, wb_data_out
    );

    modport slave (
        input  in_valid, mem_data_in, alu_data_in, wb_reg_in, reg_write_in, mem_to_reg_in,
        input  out_ready,
        output in_ready,
        output out_valid, mem_data_out, alu_data_out, wb_reg_out, reg_write_out, wb_data_out
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main entry drives the output,
// skid entry catches the beat accepted while the output is stalled.
//
//  state | meaning
//  EMPTY | no beat held, out_valid=0, in_ready=1
//  ONE   | main holds a beat, skid empty
//  TWO   | main and skid both full, in_ready=0
module pipe_skid_buf import mips_pkg::*; #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam logic [1:0] S_EMPTY = EMPTY;
    localparam logic [1:0] S_ONE   = ONE;
    localparam logic [1:0] S_TWO   = TWO;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         drain;

    // Both handshake outputs decode straight from the state register.
    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = S_TWO;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: skid-buffered beat, write-back data mux and $zero-qualified write enable.
// Optional stall cycle counter enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_pipe_reg import mips_pkg::*; #(
    parameter int unsigned DATA_W     = MIPS_DATA_W,
    parameter int unsigned REG_ADDR_W = MIPS_REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    mem_wb_pipe_reg_if.slave  bus
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int unsigned BEAT_W = 2 * DATA_W + REG_ADDR_W + 2;

    logic [BEAT_W-1:0]     beat_in;
    logic [BEAT_W-1:0]     beat_out;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_W-1:0]     mem_data_h;
    logic [DATA_W-1:0]     alu_data_h;
    logic [REG_ADDR_W-1:0] wb_reg_h;
    logic                  reg_write_h;
    logic                  mem_to_reg_h;

    assign beat_in = {bus.mem_data_in, bus.alu_data_in, bus.wb_reg_in,
                      bus.reg_write_in, bus.mem_to_reg_in};

    pipe_skid_buf #(.W(BEAT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (in_ready),
        .in_data   (beat_in),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (beat_out)
    );

    assign {mem_data_h, alu_data_h, wb_reg_h, reg_write_h, mem_to_reg_h} = beat_out;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.mem_data_out  = mem_data_h;
    assign bus.alu_data_out  = alu_data_h;
    assign bus.wb_reg_out    = wb_reg_h;
    assign bus.wb_data_out   = mem_to_reg_h ? mem_data_h : alu_data_h;
    // Writes to $zero are dropped here so the register file never sees them.
    assign bus.reg_write_out = out_valid & reg_write_h & (wb_reg_h != REG_ADDR_W'(REG_ZERO));

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (out_valid && !bus.out_ready) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg; stall counter checks build only with MEM_WB_STALL_CNT_EN.
module tb_mem_wb_pipe_reg;
    logic clk;
    logic rst;
    logic flush;
    int   vec_cnt;
    int   err_cnt;
`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                              input logic [4:0] r, input logic rw, input logic m2r);
        bus.in_valid      = v;
        bus.mem_data_in   = mem;
        bus.alu_data_in   = alu;
        bus.wb_reg_in     = r;
        bus.reg_write_in  = rw;
        bus.mem_to_reg_in = m2r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_beat(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        #2;
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vec_cnt++; if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vec_cnt++; if (bus.reg_write_out !== 1'b0) begin err_cnt++; $display("FAIL reset_reg_write: got %b want 0", bus.reg_write_out); end
        vec_cnt++; if (bus.wb_data_out !== 32'h0) begin err_cnt++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_data_out); end
        vec_cnt++; if (bus.wb_reg_out !== 5'd0) begin err_cnt++; $display("FAIL reset_wb_reg: got %0d want 0", bus.wb_reg_out); end
        vec_cnt++; if (bus.mem_data_out !== 32'h0 || bus.alu_data_out !== 32'h0) begin err_cnt++; $display("FAIL reset_data: got mem=%h alu=%h want 0/0", bus.mem_data_out, bus.alu_data_out); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 32'hAA, 32'h10, 5'd3, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        vec_cnt++; if (bus.wb_data_out !== 32'hAA) begin err_cnt++; $display("FAIL single_wb_data: got %h want aa", bus.wb_data_out); end
        vec_cnt++; if (bus.reg_write_out !== 1'b1) begin err_cnt++; $display("FAIL single_reg_write: got %b want 1", bus.reg_write_out); end
        vec_cnt++; if (bus.wb_reg_out !== 5'd3) begin err_cnt++; $display("FAIL single_wb_reg: got %0d want 3", bus.wb_reg_out); end
        vec_cnt++; if (bus.alu_data_out !== 32'h10) begin err_cnt++; $display("FAIL single_alu: got %h want 10", bus.alu_data_out); end
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_alu_select();
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 32'h55, 32'h1234, 5'd7, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.wb_data_out !== 32'h1234) begin err_cnt++; $display("FAIL alu_select_data: got %h want 1234", bus.wb_data_out); end
        vec_cnt++; if (bus.mem_data_out !== 32'h55) begin err_cnt++; $display("FAIL alu_select_mem: got %h want 55", bus.mem_data_out); end
        tick();
    endtask

    task automatic test_zero_reg();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h1, 32'h2, 5'd0, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL zero_reg_valid: got %b want 1", bus.out_valid); end
        vec_cnt++; if (bus.reg_write_out !== 1'b0) begin err_cnt++; $display("FAIL zero_reg_write: got %b want 0", bus.reg_write_out); end
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 32'h3, 32'h4, 5'd9, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.wb_reg_out !== 5'd9 || bus.reg_write_out !== 1'b0) begin err_cnt++; $display("FAIL rw0_reg_write: got reg=%0d we=%b want 9/0", bus.wb_reg_out, bus.reg_write_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_beat(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(10 + i), 1'b1, i[0]);
            tick();
            vec_cnt++;
            if (bus.wb_reg_out !== 5'(10 + i) || bus.wb_data_out !== (i[0] ? 32'h100 + 32'(i) : 32'h200 + 32'(i))
                || bus.in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_beat%0d: got reg=%0d data=%h rdy=%b want reg=%0d", i, bus.wb_reg_out, bus.wb_data_out, bus.in_ready, 10 + i);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h0, 32'h44, 5'd4, 1'b1, 1'b0);
        tick();
        vec_cnt++; if (bus.in_ready !== 1'b1 || bus.wb_reg_out !== 5'd4) begin err_cnt++; $display("FAIL bp_one: got rdy=%b reg=%0d want 1/4", bus.in_ready, bus.wb_reg_out); end
        drive_beat(1'b1, 32'h0, 32'h55, 5'd5, 1'b1, 1'b0);
        tick();
        vec_cnt++; if (bus.in_ready !== 1'b0 || bus.wb_reg_out !== 5'd4) begin err_cnt++; $display("FAIL bp_two: got rdy=%b reg=%0d want 0/4", bus.in_ready, bus.wb_reg_out); end
        drive_beat(1'b1, 32'h0, 32'h66, 5'd6, 1'b1, 1'b0);
        tick();
        vec_cnt++; if (bus.wb_reg_out !== 5'd4 || bus.wb_data_out !== 32'h44 || bus.out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold: got reg=%0d data=%h want 4/44", bus.wb_reg_out, bus.wb_data_out); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        vec_cnt++; if (bus.wb_reg_out !== 5'd5 || bus.wb_data_out !== 32'h55 || bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_second: got reg=%0d data=%h rdy=%b want 5/55/1", bus.wb_reg_out, bus.wb_data_out, bus.in_ready); end
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h0, 32'hB11, 5'd11, 1'b1, 1'b0);
        tick();
        drive_beat(1'b1, 32'h0, 32'hB12, 5'd12, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        drive_beat(1'b1, 32'h0, 32'hB13, 5'd13, 1'b1, 1'b0);
        tick();
        flush = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.reg_write_out !== 1'b0) begin err_cnt++; $display("FAIL flush_empty: got v=%b rdy=%b we=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.reg_write_out); end
        bus.out_ready = 1'b1;
        drive_beat(1'b1, 32'hE14, 32'h0, 5'd14, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.out_valid !== 1'b1 || bus.wb_reg_out !== 5'd14 || bus.wb_data_out !== 32'hE14) begin err_cnt++; $display("FAIL flush_after: got v=%b reg=%0d data=%h want 1/14/e14", bus.out_valid, bus.wb_reg_out, bus.wb_data_out); end
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_no_ghost: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h21, 32'h0, 5'd21, 1'b1, 1'b1);
        tick();
        drive_beat(1'b1, 32'h22, 32'h0, 5'd22, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        vec_cnt++; if (bus.in_ready !== 1'b0) begin err_cnt++; $display("FAIL areset_pre_two: got rdy=%b want 0", bus.in_ready); end
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.reg_write_out !== 1'b0) begin err_cnt++; $display("FAIL areset_ctrl: got v=%b rdy=%b we=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.reg_write_out); end
        vec_cnt++; if (bus.wb_data_out !== 32'h0 || bus.wb_reg_out !== 5'd0) begin err_cnt++; $display("FAIL areset_data: got data=%h reg=%0d want 0/0", bus.wb_data_out, bus.wb_reg_out); end
        tick();
        rst = 1'b0;
        tick();
        vec_cnt++; if (bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL areset_release: got %b want 0", bus.out_valid); end
    endtask

`ifdef MEM_WB_STALL_CNT_EN
    task automatic test_stall_cnt();
        vec_cnt++; if (stall_cnt !== 32'd0) begin err_cnt++; $display("FAIL stall_reset: got %0d want 0", stall_cnt); end
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 32'h31, 32'h0, 5'd31, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        vec_cnt++; if (stall_cnt !== 32'd7) begin err_cnt++; $display("FAIL stall_seven: got %0d want 7", stall_cnt); end
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        vec_cnt++; if (stall_cnt !== 32'd7 || bus.out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_flush: got cnt=%0d v=%b want 7/0", stall_cnt, bus.out_valid); end
    endtask
`endif

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_single();
        test_alu_select();
        test_zero_reg();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef MEM_WB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
